// File: rtl/hilo_acc_bank.sv
// hilo_acc_bank: NUM_BANKS {HI,LO} register pairs with direct writes and a 2-cycle MADD/MSUB engine
// Optional feature macro: HILO_BYPASS_EN (write-before-read forwarding of direct writes to the read port).
// Ports:
//   clk, rst (async, active-low)
//   rd_bank -> hi_data_out/lo_data_out (combinational read, 0 for out-of-range banks)
//   wr_bank, we_hi/hi_data_in, we_lo/lo_data_in : direct writes (MTHI/MTLO/MULT/DIV)
//   acc_valid/acc_ready, acc_op, acc_bank, acc_a, acc_b : accumulate request handshake
//   acc_done : pulse after the edge that wrote the accumulate result; busy : engine in MUL or ACC
module hilo_acc_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BANKS = 2,
  localparam int BANK_W = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BANK_W-1:0]     rd_bank,
  input  logic [BANK_W-1:0]     wr_bank,
  input  logic                  we_hi,
  input  logic [DATA_WIDTH-1:0] hi_data_in,
  input  logic                  we_lo,
  input  logic [DATA_WIDTH-1:0] lo_data_in,
  input  logic                  acc_valid,
  output logic                  acc_ready,
  input  logic [1:0]            acc_op,
  input  logic [BANK_W-1:0]     acc_bank,
  input  logic [DATA_WIDTH-1:0] acc_a,
  input  logic [DATA_WIDTH-1:0] acc_b,
  output logic                  acc_done,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] hi_data_out,
  output logic [DATA_WIDTH-1:0] lo_data_out
);
  localparam int DW = DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;
  state_t state;
  logic [DW-1:0] hi_q [NUM_BANKS];
  logic [DW-1:0] lo_q [NUM_BANKS];
  logic [1:0] op_q;
  logic [BANK_W-1:0] bank_q;
  logic [DW-1:0] a_q, b_q;
  logic [2*DW-1:0] prod_q, a_ext, b_ext, acc_cur, acc_sum;
  logic [DW-1:0] rd_hi, rd_lo;
  logic acc_wr;
  // Out-of-range indices match no bank, so reads give 0 and writes are dropped.
  always_comb begin
    rd_hi = '0;
    rd_lo = '0;
    acc_cur = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (rd_bank == BANK_W'(i)) begin
        rd_hi = hi_q[i];
        rd_lo = lo_q[i];
      end
      if (bank_q == BANK_W'(i)) acc_cur = {hi_q[i], lo_q[i]};
    end
  end
  // Sign/zero-extending to 2*DW makes the low 2*DW bits of one multiply correct for both signednesses.
  assign a_ext = op_q[0] ? {{DW{a_q[DW-1]}}, a_q} : {{DW{1'b0}}, a_q};
  assign b_ext = op_q[0] ? {{DW{b_q[DW-1]}}, b_q} : {{DW{1'b0}}, b_q};
  // acc_cur is sampled at the ACC edge, so direct writes made during MUL are folded in.
  assign acc_sum = op_q[1] ? acc_cur - prod_q : acc_cur + prod_q;
  assign acc_wr = state == ACC;
  assign acc_ready = state == IDLE;
  assign busy = ~acc_ready;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      acc_done <= 1'b0;
      op_q <= '0;
      bank_q <= '0;
      a_q <= '0;
      b_q <= '0;
      prod_q <= '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        hi_q[i] <= '0;
        lo_q[i] <= '0;
      end
    end else begin
      acc_done <= acc_wr;
      state <= state == IDLE ? (acc_valid ? MUL : IDLE) : state == MUL ? ACC : IDLE;
      if (state == IDLE && acc_valid) begin
        op_q <= acc_op;
        bank_q <= acc_bank;
        a_q <= acc_a;
        b_q <= acc_b;
      end
      if (state == MUL) prod_q <= a_ext * b_ext;
      // A direct write to the accumulating bank wins per half; the other half keeps the acc result.
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (we_hi && wr_bank == BANK_W'(i)) hi_q[i] <= hi_data_in;
        else if (acc_wr && bank_q == BANK_W'(i)) hi_q[i] <= acc_sum[2*DW-1:DW];
        if (we_lo && wr_bank == BANK_W'(i)) lo_q[i] <= lo_data_in;
        else if (acc_wr && bank_q == BANK_W'(i)) lo_q[i] <= acc_sum[DW-1:0];
      end
    end
  end
`ifdef HILO_BYPASS_EN
  logic rd_ok;
  assign rd_ok = {1'b0, rd_bank} < (BANK_W+1)'(NUM_BANKS);
  assign hi_data_out = we_hi && rd_ok && wr_bank == rd_bank ? hi_data_in : rd_hi;
  assign lo_data_out = we_lo && rd_ok && wr_bank == rd_bank ? lo_data_in : rd_lo;
`else
  assign hi_data_out = rd_hi;
  assign lo_data_out = rd_lo;
`endif
endmodule

// File: tb/tb_hilo_acc_bank.sv
// tb_hilo_acc_bank: randomized self-checking bench for hilo_acc_bank against an arithmetic model
module tb_hilo_acc_bank;
  logic clk = 0, rst = 0;
  logic [0:0] rd_bank, wr_bank, acc_bank;
  logic we_hi, we_lo, acc_valid, acc_ready, acc_done, busy;
  logic [31:0] hi_data_in, lo_data_in, acc_a, acc_b, hi_data_out, lo_data_out;
  logic [1:0] acc_op;
  logic [31:0] mhi [2];
  logic [31:0] mlo [2];
  int total = 0, bad = 0;

  hilo_acc_bank dut (
    .clk(clk), .rst(rst), .rd_bank(rd_bank), .wr_bank(wr_bank),
    .we_hi(we_hi), .hi_data_in(hi_data_in), .we_lo(we_lo), .lo_data_in(lo_data_in),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_op(acc_op), .acc_bank(acc_bank),
    .acc_a(acc_a), .acc_b(acc_b), .acc_done(acc_done), .busy(busy),
    .hi_data_out(hi_data_out), .lo_data_out(lo_data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  function automatic logic [63:0] model_acc(input logic [1:0] op, input logic [63:0] cur,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = op[0] ? 64'(longint'($signed(a)) * longint'($signed(b))) : {32'b0, a} * {32'b0, b};
    return op[1] ? cur - p : cur + p;
  endfunction

  function automatic logic [31:0] pick();
    int s;
    s = $urandom_range(0, 4);
    return s == 0 ? 32'hFFFF_FFFF : s == 1 ? 32'h8000_0000 : s == 2 ? 32'($urandom_range(0, 9)) : 32'($urandom);
  endfunction

  task automatic write_pair(input logic bk, input logic [31:0] h, input logic [31:0] l);
    we_hi = 1; we_lo = 1; wr_bank = bk; hi_data_in = h; lo_data_in = l;
    @(posedge clk); #1;
    we_hi = 0; we_lo = 0;
    mhi[bk] = h; mlo[bk] = l;
  endtask

  task automatic run_acc(input logic [1:0] op, input logic bk, input logic [31:0] a,
                         input logic [31:0] b, output int wait_n, output int lat);
    acc_op = op; acc_bank = bk; acc_a = a; acc_b = b; acc_valid = 1; rd_bank = bk;
    wait_n = 0;
    while (!acc_ready && wait_n < 10) begin @(posedge clk); #1; wait_n++; end
    @(posedge clk); #1;
    acc_valid = 0;
    lat = 0;
    while (!acc_done && lat < 8) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset();
    int seen;
    for (int b = 0; b < 2; b++) begin
      rd_bank = 1'(b); #1;
      total++; if (hi_data_out !== 0 || lo_data_out !== 0) begin bad++; $display("FAIL reset_init_bank%0d got=%h_%h want=0", b, hi_data_out, lo_data_out); end
    end
    total++; if (acc_ready !== 1 || busy !== 0 || acc_done !== 0) begin bad++; $display("FAIL reset_init_ctl got rdy=%b busy=%b done=%b want 1 0 0", acc_ready, busy, acc_done); end
    @(posedge clk); #1; rst = 1;
    write_pair(0, 32'h1111_2222, 32'h3333_4444);
    write_pair(1, 32'h5555_6666, 32'h7777_8888);
    acc_op = 2'b00; acc_bank = 0; acc_a = 3; acc_b = 5; acc_valid = 1;
    @(posedge clk); #1; acc_valid = 0;
    total++; if (busy !== 1) begin bad++; $display("FAIL reset_pre_busy got=%b want=1", busy); end
    #2 rst = 0; #1;
    for (int b = 0; b < 2; b++) begin
      rd_bank = 1'(b); #1;
      total++; if (hi_data_out !== 0 || lo_data_out !== 0) begin bad++; $display("FAIL reset_mid_bank%0d got=%h_%h want=0", b, hi_data_out, lo_data_out); end
    end
    total++; if (acc_ready !== 1 || acc_done !== 0) begin bad++; $display("FAIL reset_mid_ctl got rdy=%b done=%b want 1 0", acc_ready, acc_done); end
    repeat (2) @(posedge clk);
    #1 rst = 1;
    seen = 0;
    repeat (4) begin @(posedge clk); #1; if (acc_done) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL reset_no_done got=%0d want=0", seen); end
    rd_bank = 0; #1;
    total++; if (hi_data_out !== 0 || lo_data_out !== 0) begin bad++; $display("FAIL reset_after got=%h_%h want=0", hi_data_out, lo_data_out); end
    for (int b = 0; b < 2; b++) begin mhi[b] = 0; mlo[b] = 0; end
  endtask

  task automatic test_direct_write();
    logic wh, wl, wb;
    logic [31:0] dh, dl;
    wr_bank = 1; we_hi = 1; hi_data_in = 32'hDEAD_BEEF; rd_bank = 0;
    @(posedge clk); #1; we_hi = 0;
    mhi[1] = 32'hDEAD_BEEF;
    total++; if (hi_data_out !== 0) begin bad++; $display("FAIL wr_other_bank got=%h want=0", hi_data_out); end
    rd_bank = 1; #1;
    total++; if (hi_data_out !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_bank1_hi got=%h want=deadbeef", hi_data_out); end
    total++; if (lo_data_out !== 0) begin bad++; $display("FAIL wr_bank1_lo got=%h want=0", lo_data_out); end
    for (int n = 0; n < 20; n++) begin
      wh = 1'($urandom); wl = 1'($urandom); wb = 1'($urandom); dh = $urandom; dl = $urandom;
      we_hi = wh; we_lo = wl; wr_bank = wb; hi_data_in = dh; lo_data_in = dl;
      @(posedge clk); #1; we_hi = 0; we_lo = 0;
      if (wh) mhi[wb] = dh;
      if (wl) mlo[wb] = dl;
      for (int b = 0; b < 2; b++) begin
        rd_bank = 1'(b); #1;
        total++; if (hi_data_out !== mhi[b] || lo_data_out !== mlo[b]) begin bad++; $display("FAIL wr_rand%0d_bank%0d got=%h_%h want=%h_%h", n, b, hi_data_out, lo_data_out, mhi[b], mlo[b]); end
      end
    end
  endtask

  task automatic test_madd();
    int w, l;
    logic [1:0] op;
    logic bk;
    logic [31:0] a, b;
    logic [63:0] e;
    write_pair(0, 0, 5);
    run_acc(2'b01, 0, 32'hFFFF_FFFE, 3, w, l);
    total++; if (w !== 0 || l !== 2) begin bad++; $display("FAIL madd_latency got wait=%0d lat=%0d want 0 2", w, l); end
    total++; if (hi_data_out !== 32'hFFFF_FFFF || lo_data_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL madd_neg got=%h_%h want=ffffffff_ffffffff", hi_data_out, lo_data_out); end
    @(posedge clk); #1;
    total++; if (acc_done !== 0 || acc_ready !== 1) begin bad++; $display("FAIL done_pulse got done=%b rdy=%b want 0 1", acc_done, acc_ready); end
    write_pair(0, 0, 0);
    run_acc(2'b10, 0, 1, 1, w, l);
    total++; if (hi_data_out !== 32'hFFFF_FFFF || lo_data_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL msubu_wrap got=%h_%h want=ffffffff_ffffffff", hi_data_out, lo_data_out); end
    write_pair(0, 0, 0);
    run_acc(2'b00, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w, l);
    total++; if (hi_data_out !== 32'hFFFF_FFFE || lo_data_out !== 32'h0000_0001) begin bad++; $display("FAIL maddu_max got=%h_%h want=fffffffe_00000001", hi_data_out, lo_data_out); end
    mhi[0] = 32'hFFFF_FFFE; mlo[0] = 1;
    for (int n = 0; n < 24; n++) begin
      op = 2'($urandom); bk = 1'($urandom); a = pick(); b = pick();
      e = model_acc(op, {mhi[bk], mlo[bk]}, a, b);
      run_acc(op, bk, a, b, w, l);
      mhi[bk] = e[63:32]; mlo[bk] = e[31:0];
      total++; if (l !== 2 || hi_data_out !== mhi[bk] || lo_data_out !== mlo[bk]) begin bad++; $display("FAIL acc_rand%0d op=%b a=%h b=%h got=%h_%h lat=%0d want=%h_%h lat=2", n, op, a, b, hi_data_out, lo_data_out, l, mhi[bk], mlo[bk]); end
      rd_bank = ~bk; #1;
      total++; if (hi_data_out !== mhi[~bk] || lo_data_out !== mlo[~bk]) begin bad++; $display("FAIL acc_other%0d got=%h_%h want=%h_%h", n, hi_data_out, lo_data_out, mhi[~bk], mlo[~bk]); end
    end
  endtask

  task automatic test_collision();
    write_pair(0, 0, 0);
    acc_op = 2'b00; acc_bank = 0; acc_a = 1; acc_b = 1; acc_valid = 1; rd_bank = 0;
    @(posedge clk); #1; acc_valid = 0;
    @(posedge clk); #1;
    total++; if (acc_done !== 0) begin bad++; $display("FAIL coll_early_done got=%b want=0", acc_done); end
    we_lo = 1; lo_data_in = 7; wr_bank = 0;
    @(posedge clk); #1; we_lo = 0;
    total++; if (acc_done !== 1) begin bad++; $display("FAIL coll_done got=%b want=1", acc_done); end
    total++; if (hi_data_out !== 0 || lo_data_out !== 7) begin bad++; $display("FAIL coll_lo_wins got=%h_%h want=0_7", hi_data_out, lo_data_out); end
    mhi[0] = 0; mlo[0] = 7;
    write_pair(1, 0, 100);
    acc_op = 2'b00; acc_bank = 1; acc_a = 3; acc_b = 4; acc_valid = 1;
    @(posedge clk); #1; acc_valid = 0;
    we_hi = 1; hi_data_in = 5; wr_bank = 1;
    @(posedge clk); #1;
    hi_data_in = 32'h0000_AAAA; wr_bank = 0;
    @(posedge clk); #1; we_hi = 0;
    mhi[1] = 5; mlo[1] = 112; mhi[0] = 32'h0000_AAAA;
    for (int b = 0; b < 2; b++) begin
      rd_bank = 1'(b); #1;
      total++; if (hi_data_out !== mhi[b] || lo_data_out !== mlo[b]) begin bad++; $display("FAIL mul_window_bank%0d got=%h_%h want=%h_%h", b, hi_data_out, lo_data_out, mhi[b], mlo[b]); end
    end
  endtask

  task automatic test_busy_ignore();
    int seen;
    write_pair(1, 0, 0);
    acc_op = 2'b00; acc_bank = 1; acc_a = 2; acc_b = 3; acc_valid = 1;
    @(posedge clk); #1;
    acc_op = 2'b11; acc_bank = 0; acc_a = 100; acc_b = 100;
    total++; if (acc_ready !== 0 || busy !== 1) begin bad++; $display("FAIL busy_flags got rdy=%b busy=%b want 0 1", acc_ready, busy); end
    repeat (2) @(posedge clk);
    #1 acc_valid = 0;
    total++; if (acc_done !== 1) begin bad++; $display("FAIL busy_first_done got=%b want=1", acc_done); end
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (acc_done) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL busy_ignored_done got=%0d want=0", seen); end
    mlo[1] = 6;
    for (int b = 0; b < 2; b++) begin
      rd_bank = 1'(b); #1;
      total++; if (hi_data_out !== mhi[b] || lo_data_out !== mlo[b]) begin bad++; $display("FAIL busy_bank%0d got=%h_%h want=%h_%h", b, hi_data_out, lo_data_out, mhi[b], mlo[b]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops [4];
    logic [31:0] as [4];
    logic [31:0] bs [4];
    logic [63:0] e;
    int nacc, ndone, last;
    logic acc;
    for (int i = 0; i < 4; i++) begin ops[i] = 2'($urandom); as[i] = pick(); bs[i] = pick(); end
    rd_bank = 1; acc_bank = 1;
    acc_op = ops[0]; acc_a = as[0]; acc_b = bs[0]; acc_valid = 1;
    nacc = 0; ndone = 0; last = -1;
    for (int cyc = 0; cyc < 40 && ndone < 4; cyc++) begin
      acc = acc_valid && acc_ready;
      @(posedge clk); #1;
      if (acc) begin
        nacc++;
        if (nacc < 4) begin acc_op = ops[nacc]; acc_a = as[nacc]; acc_b = bs[nacc]; end
        else acc_valid = 0;
      end
      if (acc_done) begin
        e = model_acc(ops[ndone], {mhi[1], mlo[1]}, as[ndone], bs[ndone]);
        mhi[1] = e[63:32]; mlo[1] = e[31:0];
        total++; if (hi_data_out !== mhi[1] || lo_data_out !== mlo[1]) begin bad++; $display("FAIL b2b_val%0d got=%h_%h want=%h_%h", ndone, hi_data_out, lo_data_out, mhi[1], mlo[1]); end
        if (last >= 0) begin
          total++; if (cyc - last !== 3) begin bad++; $display("FAIL b2b_spacing%0d got=%0d want=3", ndone, cyc - last); end
        end
        last = cyc; ndone++;
      end
    end
    acc_valid = 0;
    total++; if (ndone !== 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", ndone); end
  endtask

  task automatic test_bypass();
    logic [31:0] want;
    write_pair(0, 11, 22);
    rd_bank = 0; wr_bank = 0; we_lo = 1; lo_data_in = 9; #1;
`ifdef HILO_BYPASS_EN
    want = 9;
`else
    want = 22;
`endif
    total++; if (lo_data_out !== want) begin bad++; $display("FAIL bypass_same_cycle got=%h want=%h", lo_data_out, want); end
    total++; if (hi_data_out !== 11) begin bad++; $display("FAIL bypass_hi_untouched got=%h want=0000000b", hi_data_out); end
    @(posedge clk); #1; we_lo = 0; mlo[0] = 9;
    total++; if (lo_data_out !== 9) begin bad++; $display("FAIL bypass_next_cycle got=%h want=9", lo_data_out); end
    we_hi = 1; wr_bank = 1; hi_data_in = 33; #1;
    total++; if (hi_data_out !== 11) begin bad++; $display("FAIL bypass_other_bank got=%h want=0000000b", hi_data_out); end
    @(posedge clk); #1; we_hi = 0; mhi[1] = 33;
  endtask

  initial begin
    we_hi = 0; we_lo = 0; acc_valid = 0; rd_bank = 0; wr_bank = 0; acc_bank = 0;
    hi_data_in = 0; lo_data_in = 0; acc_a = 0; acc_b = 0; acc_op = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_direct_write();
    test_madd();
    test_collision();
    test_busy_ignore();
    test_back_to_back();
    test_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
